// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared definitions for the register-file write-back scheduler:
// requester indices, fixed register numbers, age width and base priority order.
package regfile_wb_scheduler_pkg;

  localparam int NUM_REQ  = 3;
  localparam int REQ_MEM  = 0;
  localparam int REQ_LINK = 1;
  localparam int REQ_ALU  = 2;

  localparam int LINK_REG = 31;
  localparam int ZERO_REG = 0;

  localparam int AGE_W    = 3;

  // Highest priority first
  localparam int BASE_ORDER [NUM_REQ] = '{REQ_MEM, REQ_LINK, REQ_ALU};

  // One-hot pick of the highest base-priority requester set in m
  function automatic logic [NUM_REQ-1:0] base_pick(input logic [NUM_REQ-1:0] m);
    logic [NUM_REQ-1:0] g;
    g = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (m[BASE_ORDER[k]]) g = NUM_REQ'(1) << BASE_ORDER[k];
    end
    return g;
  endfunction

endpackage

// File: rtl/regfile_wb_scheduler_arbiter.sv
// wb_age_arbiter: per-requester age counters plus combinational one-hot grant.
// A requester whose age reached AGE_MAX overrides the base order; ties among
// aged requesters fall back to the base order.
module wb_age_arbiter
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int AGE_MAX = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic [NUM_REQ-1:0] req_vld,
  output logic [NUM_REQ-1:0] grant
);

  localparam logic [AGE_W-1:0] AGE_TOP = AGE_W'(AGE_MAX);

  logic [AGE_W-1:0]   age_p1 [NUM_REQ];
  logic [NUM_REQ-1:0] aged;

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a >= AGE_TOP) ? AGE_TOP : a + AGE_W'(1);
  endfunction

  // Grant: aged requesters first, otherwise plain base order
  always_comb begin
    aged = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      aged[i] = req_vld[i] && (age_p1[i] == AGE_TOP);
    end
    grant = (|aged) ? base_pick(aged) : base_pick(req_vld);
  end

  // Age counters: count denied cycles, clear on grant, idle or flush
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REQ; i++) age_p1[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_REQ; i++) age_p1[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_vld[i] || grant[i]) age_p1[i] <= '0;
        else                         age_p1[i] <= age_sat_inc(age_p1[i]);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// regfile_wb_scheduler: shares the register-file write port among MEM, LINK
// and ALU write-back requesters, registers the winning write and keeps a
// pending-write scoreboard for decode hazard detection.
// Optional macro WB_FORWARD_EN adds write-port forwarding outputs and lets the
// hazard check ignore registers released by this cycle's grant.
module regfile_wb_scheduler
  import regfile_wb_scheduler_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int AGE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              link_valid,
  input  logic [DATA_W-1:0] link_data,
  output logic              link_ready,
  input  logic              claim_en,
  input  logic [ADDR_W-1:0] claim_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              hazard,
`ifdef WB_FORWARD_EN
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit,
  output logic [DATA_W-1:0] fwd_rs_data,
  output logic [DATA_W-1:0] fwd_rt_data,
`endif
  output logic [31:0]       busy_mask,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
);

  logic [NUM_REQ-1:0] req_vld;
  logic [NUM_REQ-1:0] grant;

  logic               vld_p0;
  logic [ADDR_W-1:0]  win_addr_p0;
  logic [DATA_W-1:0]  win_data_p0;

  logic               vld_p1;
  logic [ADDR_W-1:0]  wr_addr_p1;
  logic [DATA_W-1:0]  wr_data_p1;

  logic [31:0]        busy_p1;
  logic [31:0]        clr_mask;
  logic [31:0]        set_mask;
  logic [31:0]        busy_nxt;
  logic [31:0]        hz_mask;

  assign req_vld[REQ_MEM]  = mem_valid;
  assign req_vld[REQ_LINK] = link_valid;
  assign req_vld[REQ_ALU]  = alu_valid;

  wb_age_arbiter #(
    .AGE_MAX (AGE_MAX)
  ) u_arb (
    .clock   (clock),
    .reset   (reset),
    .flush   (flush),
    .req_vld (req_vld),
    .grant   (grant)
  );

  assign mem_ready  = grant[REQ_MEM];
  assign link_ready = grant[REQ_LINK];
  assign alu_ready  = grant[REQ_ALU];

  // p0: select the winner; a write to register 0 is accepted but dropped
  always_comb begin
    win_addr_p0 = '0;
    win_data_p0 = '0;
    if (grant[REQ_MEM]) begin
      win_addr_p0 = mem_addr;
      win_data_p0 = mem_data;
    end else if (grant[REQ_LINK]) begin
      win_addr_p0 = ADDR_W'(LINK_REG);
      win_data_p0 = link_data;
    end else if (grant[REQ_ALU]) begin
      win_addr_p0 = alu_addr;
      win_data_p0 = alu_data;
    end
    vld_p0 = (|grant) && (win_addr_p0 != ADDR_W'(ZERO_REG));
  end

  // p1: registered write port; address/data hold when nothing is written
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1     <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        wr_addr_p1 <= win_addr_p0;
        wr_data_p1 <= win_data_p0;
      end
    end
  end

  assign wr_en   = vld_p1;
  assign wr_addr = wr_addr_p1;
  assign wr_data = wr_data_p1;

  // Scoreboard next state: grant clears, claim sets (set wins), flush empties
  always_comb begin
    clr_mask = vld_p0 ? (32'd1 << win_addr_p0) : 32'd0;
    set_mask = (claim_en && !flush && (claim_addr != ADDR_W'(ZERO_REG)))
               ? (32'd1 << claim_addr) : 32'd0;
    busy_nxt = flush ? 32'd0 : ((busy_p1 & ~clr_mask) | set_mask);
  end

  // Scoreboard register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_p1 <= '0;
    else        busy_p1 <= busy_nxt;
  end

  assign busy_mask = busy_p1;

  // Hazard lookup on both decode sources
  always_comb begin
`ifdef WB_FORWARD_EN
    hz_mask = busy_p1 & ~clr_mask;
`else
    hz_mask = busy_p1;
`endif
    hazard = hz_mask[rs_addr] | hz_mask[rt_addr];
  end

`ifdef WB_FORWARD_EN
  assign fwd_rs_hit  = vld_p1 && (wr_addr_p1 == rs_addr) && (rs_addr != ADDR_W'(ZERO_REG));
  assign fwd_rt_hit  = vld_p1 && (wr_addr_p1 == rt_addr) && (rt_addr != ADDR_W'(ZERO_REG));
  assign fwd_rs_data = wr_data_p1;
  assign fwd_rt_data = wr_data_p1;
`endif

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler (default build, AGE_MAX=3).
module tb_regfile_wb_scheduler;

  logic        clock;
  logic        reset;
  logic        flush;
  logic        alu_valid;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        link_valid;
  logic [31:0] link_data;
  logic        link_ready;
  logic        claim_en;
  logic [4:0]  claim_addr;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic        hazard;
  logic [31:0] busy_mask;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_wb_scheduler #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .AGE_MAX (3)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .link_valid (link_valid),
    .link_data  (link_data),
    .link_ready (link_ready),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .hazard     (hazard),
    .busy_mask  (busy_mask),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    link_valid = 1'b0; link_data = '0;
    claim_en = 1'b0; claim_addr = '0; rs_addr = '0; rt_addr = '0;

    #3;
    check_eq("rst_wr_en",   wr_en,     0);
    check_eq("rst_wr_addr", wr_addr,   0);
    check_eq("rst_wr_data", wr_data,   0);
    check_eq("rst_busy",    busy_mask, 0);
    #9 reset = 1'b1;
    tick();

    // Single ALU write
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234; #1;
    check_eq("alu_ready",   alu_ready, 1);
    check_eq("alu_mem_rdy", mem_ready, 0);
    tick();
    alu_valid = 1'b0;
    check_eq("alu_wr_en",   wr_en,   1);
    check_eq("alu_wr_addr", wr_addr, 5);
    check_eq("alu_wr_data", wr_data, 32'h1234);
    tick();
    check_eq("idle_wr_en",   wr_en,   0);
    check_eq("idle_wr_hold", wr_addr, 5);

    // MEM beats ALU, ALU follows
    mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h66;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h77; #1;
    check_eq("mva_mem_rdy", mem_ready, 1);
    check_eq("mva_alu_rdy", alu_ready, 0);
    tick();
    mem_valid = 1'b0;
    check_eq("mva_wr1_addr", wr_addr, 6);
    check_eq("mva_wr1_data", wr_data, 32'h66);
    #1;
    check_eq("mva_alu_rdy2", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    check_eq("mva_wr2_en",   wr_en,   1);
    check_eq("mva_wr2_addr", wr_addr, 7);
    check_eq("mva_wr2_data", wr_data, 32'h77);
    tick();

    // LINK beats ALU, writes r31
    link_valid = 1'b1; link_data = 32'h104;
    alu_valid = 1'b1; alu_addr = 5'd13; alu_data = 32'hD; #1;
    check_eq("lva_link_rdy", link_ready, 1);
    check_eq("lva_alu_rdy",  alu_ready,  0);
    tick();
    link_valid = 1'b0;
    check_eq("lva_wr1_addr", wr_addr, 31);
    check_eq("lva_wr1_data", wr_data, 32'h104);
    tick();
    alu_valid = 1'b0;
    check_eq("lva_wr2_addr", wr_addr, 13);
    tick();

    // Aging: ALU starved by MEM for 3 cycles, wins on the 4th
    mem_valid = 1'b1; mem_addr = 5'd9;  mem_data = 32'h99;
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA; #1;
    for (int c = 1; c <= 4; c++) begin
      check_eq($sformatf("age_alu_rdy_c%0d", c), alu_ready, (c == 4));
      check_eq($sformatf("age_mem_rdy_c%0d", c), mem_ready, (c != 4));
      tick();
      check_eq($sformatf("age_wr_addr_c%0d", c), wr_addr, (c == 4) ? 10 : 9);
    end
    mem_valid = 1'b0; alu_valid = 1'b0;
    tick();

    // Scoreboard claim / release
    claim_en = 1'b1; claim_addr = 5'd8;
    tick();
    claim_en = 1'b0; rs_addr = 5'd8; #1;
    check_eq("sb_busy8",   busy_mask, 32'h100);
    check_eq("sb_hazard1", hazard,    1);
    alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h88;
    tick();
    alu_valid = 1'b0; #1;
    check_eq("sb_hazard0", hazard,    0);
    check_eq("sb_busy0",   busy_mask, 0);

    // Claim and grant of r8 together: set wins
    claim_en = 1'b1; claim_addr = 5'd8;
    tick();
    alu_valid = 1'b1; alu_addr = 5'd8; alu_data = 32'h81; #1;
    check_eq("sw_alu_rdy", alu_ready, 1);
    tick();
    claim_en = 1'b0; alu_valid = 1'b0; rs_addr = 5'd0; rt_addr = 5'd8; #1;
    check_eq("sw_busy",    busy_mask, 32'h100);
    check_eq("sw_wr_data", wr_data,   32'h81);
    check_eq("sw_hazard",  hazard,    1);
    alu_valid = 1'b1; alu_data = 32'h82;
    tick();
    alu_valid = 1'b0; #1;
    check_eq("sw_busy_clr", busy_mask, 0);
    check_eq("sw_hz_clr",   hazard,    0);

    // Register 0: accepted, never written, never claimed
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'hDEAD; #1;
    check_eq("r0_alu_rdy", alu_ready, 1);
    tick();
    alu_valid = 1'b0;
    check_eq("r0_wr_en",   wr_en,   0);
    check_eq("r0_wr_hold", wr_addr, 8);
    claim_en = 1'b1; claim_addr = 5'd0;
    tick();
    claim_en = 1'b0;
    check_eq("r0_busy", busy_mask, 0);

    // Flush with a same-cycle claim
    for (int r = 8; r <= 11; r++) begin
      claim_en = 1'b1; claim_addr = 5'(r);
      tick();
    end
    claim_en = 1'b0; #1;
    check_eq("fl_busy_pre", busy_mask, 32'h0000_0F00);
    flush = 1'b1; claim_en = 1'b1; claim_addr = 5'd3;
    tick();
    flush = 1'b0; claim_en = 1'b0; #1;
    check_eq("fl_busy_post", busy_mask, 0);

    // Reset during an in-flight write
    alu_valid = 1'b1; alu_addr = 5'd12; alu_data = 32'hC; #1;
    tick();
    alu_valid = 1'b0;
    check_eq("rm_wr_en_pre", wr_en, 1);
    reset = 1'b0; #1;
    check_eq("rm_wr_en",   wr_en,   0);
    check_eq("rm_wr_addr", wr_addr, 0);
    check_eq("rm_wr_data", wr_data, 0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("rm_wr_en_post", wr_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
